alt_vipcti131_common_vip_packet_encoder: RTL and testbench

//  Avalon-ST Video packet encoder; the transmit end of the VIP stream.

---
 rtl/alt_vipcti131_common_vip_pkg.sv | 22 ++
 rtl/alt_vipcti131_common_vip_ctrl_serialiser.sv | 38 +++
 rtl/alt_vipcti131_common_vip_packet_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_alt_vipcti131_common_vip_packet_encoder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipcti131_common_vip_pkg.sv
// Shared types and constants for the VIP packet encoder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alt_vipcti131_common_vip_pkg;

    localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
    localparam int         CTRL_NIBBLES   = 9;

    typedef enum logic [2:0] {
        IDLE,
        CTRL_HDR,
        CTRL_BODY,
        VID_HDR,
        VID_DATA
    } enc_state_e;

    function automatic int ctrl_beats(input int s);
        return (CTRL_NIBBLES + s - 1) / s;
    endfunction

endpackage

// File: rtl/alt_vipcti131_common_vip_ctrl_serialiser.sv
// Maps {width,height,interlaced} and a body beat index to one control-packet beat.
// Latency: purely combinational.
// Backpressure: none; the caller only advances the beat index when the beat is loaded.
module alt_vipcti131_common_vip_ctrl_serialiser
    import alt_vipcti131_common_vip_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int IDX_W            = 2
) (
    input  logic [15:0]                                  width_i,
    input  logic [15:0]                                  height_i,
    input  logic [3:0]                                   interlaced_i,
    input  logic [IDX_W-1:0]                             beat_idx_i,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  beat_o,
    output logic                                         last_o
);

    localparam int BEATS = ctrl_beats(SYMBOLS_PER_BEAT);

    logic [4*CTRL_NIBBLES-1:0] nibbles;

    // Most significant nibble of width is nibble 0.
    assign nibbles = {width_i, height_i, interlaced_i};

    always_comb begin
        beat_o = '0;
        for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
            if (int'(beat_idx_i) * SYMBOLS_PER_BEAT + s < CTRL_NIBBLES) begin
                beat_o[s*BITS_PER_SYMBOL +: 4] =
                    nibbles[(CTRL_NIBBLES - 1 - (int'(beat_idx_i) * SYMBOLS_PER_BEAT + s)) * 4 +: 4];
            end
        end
    end

    assign last_o = (int'(beat_idx_i) == BEATS - 1);

endmodule

// File: rtl/alt_vipcti131_common_vip_packet_encoder.sv
// Avalon-ST Video packet encoder: frames control (0xF) and video (0x0) packets; optional VIP_ENC_LENGTH_CHECK_EN.
// Latency: one output register stage; accepted pixel appears on dout the next cycle.
// Backpressure: output register advances on ~dout_valid | dout_ready; din_ready only in VID_DATA when advancing.
module alt_vipcti131_common_vip_packet_encoder
    import alt_vipcti131_common_vip_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         din_valid,
    output logic                                         din_ready,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  din_data,
    input  logic                                         din_end_of_video,
    input  logic                                         ctrl_send,
    input  logic [15:0]                                  ctrl_width,
    input  logic [15:0]                                  ctrl_height,
    input  logic [3:0]                                   ctrl_interlaced,
    output logic                                         ctrl_busy,
    input  logic                                         dout_ready,
    output logic                                         dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  dout_data,
    output logic                                         dout_startofpacket,
    output logic                                         dout_endofpacket
`ifdef VIP_ENC_LENGTH_CHECK_EN
    ,
    output logic                                         length_error,
    output logic [31:0]                                  last_pkt_pixels
`endif
);

    localparam int W     = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int CB    = ctrl_beats(SYMBOLS_PER_BEAT);
    localparam int IDX_W = (CB > 1) ? $clog2(CB) : 1;

    enc_state_e       state_q, state_d;
    logic             vld_q, vld_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [W-1:0]     dat_q, dat_d;
    logic             out_ctrl_q, out_ctrl_d;
    logic [IDX_W-1:0] beat_q, beat_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [15:0]      w_q, h_q;
    logic [3:0]       il_q;

    logic             adv;
    logic             latch;
    logic             pend_now;
    logic             pend_take;
    logic [W-1:0]     ser_beat;
    logic             ser_last;

    assign adv      = ~vld_q | dout_ready;
    assign latch    = ctrl_send & ~busy_q;
    // A request arriving this cycle already wins over a same-cycle pixel in IDLE.
    assign pend_now = pend_q | latch;

    assign din_ready = (state_q == VID_DATA) & adv;

    alt_vipcti131_common_vip_ctrl_serialiser #(
        .BITS_PER_SYMBOL  (BITS_PER_SYMBOL),
        .SYMBOLS_PER_BEAT (SYMBOLS_PER_BEAT),
        .IDX_W            (IDX_W)
    ) u_ser (
        .width_i      (w_q),
        .height_i     (h_q),
        .interlaced_i (il_q),
        .beat_idx_i   (beat_q),
        .beat_o       (ser_beat),
        .last_o       (ser_last)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        vld_d      = vld_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        dat_d      = dat_q;
        out_ctrl_d = out_ctrl_q;
        pend_take  = 1'b0;
        if (adv) begin
            vld_d      = 1'b0;
            sop_d      = 1'b0;
            eop_d      = 1'b0;
            out_ctrl_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pend_now)       state_d = CTRL_HDR;
                    else if (din_valid) state_d = VID_HDR;
                end
                CTRL_HDR: begin
                    vld_d      = 1'b1;
                    sop_d      = 1'b1;
                    dat_d      = '0;
                    dat_d[3:0] = PKT_TYPE_CTRL;
                    out_ctrl_d = 1'b1;
                    pend_take  = 1'b1;
                    beat_d     = '0;
                    state_d    = CTRL_BODY;
                end
                CTRL_BODY: begin
                    vld_d      = 1'b1;
                    dat_d      = ser_beat;
                    eop_d      = ser_last;
                    out_ctrl_d = 1'b1;
                    if (ser_last) state_d = IDLE;
                    else          beat_d  = beat_q + 1'b1;
                end
                VID_HDR: begin
                    vld_d      = 1'b1;
                    sop_d      = 1'b1;
                    dat_d      = '0;
                    dat_d[3:0] = PKT_TYPE_VIDEO;
                    state_d    = VID_DATA;
                end
                VID_DATA: begin
                    if (din_valid) begin
                        vld_d = 1'b1;
                        dat_d = din_data;
                        eop_d = din_end_of_video;
                        if (din_end_of_video) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pend_d = pend_now & ~pend_take;
    // Busy spans request, transmission and the final handshake of the control EOP.
    assign busy_d = latch ? 1'b1 :
                    (vld_q & dout_ready & eop_q & out_ctrl_q) ? 1'b0 : busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            dat_q      <= '0;
            out_ctrl_q <= 1'b0;
            beat_q     <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            w_q        <= 16'd640;
            h_q        <= 16'd480;
            il_q       <= 4'd0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            dat_q      <= dat_d;
            out_ctrl_q <= out_ctrl_d;
            beat_q     <= beat_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            if (latch) begin
                w_q  <= ctrl_width;
                h_q  <= ctrl_height;
                il_q <= ctrl_interlaced;
            end
        end
    end

    assign ctrl_busy          = busy_q;
    assign dout_valid         = vld_q;
    assign dout_data          = dat_q;
    assign dout_startofpacket = sop_q;
    assign dout_endofpacket   = eop_q;

`ifdef VIP_ENC_LENGTH_CHECK_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_fin;
    logic [31:0] sent_wh_q;
    logic [31:0] last_q;
    logic        lerr_q;

    assign cnt_fin = cnt_q + 32'd1;

    // Expected area is captured when the control header goes out, not when requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            sent_wh_q <= 32'd640 * 32'd480;
            last_q    <= '0;
            lerr_q    <= 1'b0;
        end else begin
            if (pend_take) sent_wh_q <= 32'(w_q) * 32'(h_q);
            if (adv && state_q == VID_HDR) begin
                cnt_q <= '0;
            end else if (din_valid && din_ready) begin
                cnt_q <= cnt_fin;
                if (din_end_of_video) begin
                    last_q <= (cnt_fin * 32'(SYMBOLS_PER_BEAT)) / 32'd3;
                    if (cnt_fin != sent_wh_q) lerr_q <= 1'b1;
                end
            end
        end
    end

    assign length_error    = lerr_q;
    assign last_pkt_pixels = last_q;
`endif

endmodule

// File: tb/tb_alt_vipcti131_common_vip_packet_encoder.sv
// Bench for the VIP packet encoder: table-driven control packets, directed corner sequences and random traffic.
module tb_alt_vipcti131_common_vip_packet_encoder;

    localparam int B  = 8;
    localparam int S  = 3;
    localparam int W  = B * S;
    localparam int CB = (9 + S - 1) / S;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sop;
        logic         eop;
    } beat_t;

    typedef struct {
        logic [15:0]  w;
        logic [15:0]  h;
        logic [3:0]   il;
        int           mode;
        logic [W-1:0] b1;
        logic [W-1:0] b2;
        logic [W-1:0] b3;
    } ctrl_vec_t;

    logic         clk;
    logic         rst;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] din_data;
    logic         din_end_of_video;
    logic         ctrl_send;
    logic [15:0]  ctrl_width;
    logic [15:0]  ctrl_height;
    logic [3:0]   ctrl_interlaced;
    logic         ctrl_busy;
    logic         dout_ready;
    logic         dout_valid;
    logic [W-1:0] dout_data;
    logic         dout_startofpacket;
    logic         dout_endofpacket;
`ifdef VIP_ENC_LENGTH_CHECK_EN
    logic         length_error;
    logic [31:0]  last_pkt_pixels;
`endif

    alt_vipcti131_common_vip_packet_encoder #(
        .BITS_PER_SYMBOL  (B),
        .SYMBOLS_PER_BEAT (S)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .din_valid          (din_valid),
        .din_ready          (din_ready),
        .din_data           (din_data),
        .din_end_of_video   (din_end_of_video),
        .ctrl_send          (ctrl_send),
        .ctrl_width         (ctrl_width),
        .ctrl_height        (ctrl_height),
        .ctrl_interlaced    (ctrl_interlaced),
        .ctrl_busy          (ctrl_busy),
        .dout_ready         (dout_ready),
        .dout_valid         (dout_valid),
        .dout_data          (dout_data),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket)
`ifdef VIP_ENC_LENGTH_CHECK_EN
        ,
        .length_error       (length_error),
        .last_pkt_pixels    (last_pkt_pixels)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           tests;
    int           errs;
    int           mode;
    bit           mon_en;
    bit           acc_seen;
    bit           lat_pend;
    bit           hold_vld;
    logic [W-1:0] lat_exp;
    beat_t        hold_b;
    beat_t        exp_q[$];
    ctrl_vec_t    tbl[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard and protocol observer, sampled on the falling edge.
    task automatic monitor_sample();
        beat_t cur;
        beat_t e;
        cur = {dout_data, dout_startofpacket, dout_endofpacket};
        if (mon_en) begin
            if (lat_pend) begin
                chk("latency_valid", 64'(dout_valid), 64'd1);
                chk("latency_data", 64'(dout_data), 64'(lat_exp));
            end
            if (hold_vld) begin
                chk("stable_valid", 64'(dout_valid), 64'd1);
                chk("stable_beat", 64'(cur), 64'(hold_b));
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errs++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(cur), 64'(e));
                end
            end
        end
        lat_pend = mon_en && din_valid && din_ready;
        lat_exp  = din_data;
        hold_vld = mon_en && dout_valid && !dout_ready;
        hold_b   = cur;
        acc_seen = din_valid && din_ready;
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor_sample();
        @(posedge clk);
        #1;
        case (mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            default: dout_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // Reference: header beat, then nibble k of {w,h,il} in low 4 bits of symbol k%S of body beat k/S.
    task automatic push_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        logic [35:0]  word;
        logic [W-1:0] d;
        logic         lastb;
        int           k;
        word = {w, h, il};
        exp_q.push_back({24'h00000F, 1'b1, 1'b0});
        for (int j = 0; j < CB; j++) begin
            d = '0;
            for (int s = 0; s < S; s++) begin
                k = j * S + s;
                if (k < 9) d[s*B +: 4] = word[35 - 4*k -: 4];
            end
            lastb = (j == CB - 1);
            exp_q.push_back({d, 1'b0, lastb});
        end
    endtask

    task automatic drive_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        for (int c = 0; c < 3000 && ctrl_busy; c++) cyc();
        if (ctrl_busy) chk("ctrl_busy_timeout", 64'(ctrl_busy), 64'd0);
        ctrl_send       = 1'b1;
        ctrl_width      = w;
        ctrl_height     = h;
        ctrl_interlaced = il;
        cyc();
        ctrl_send = 1'b0;
    endtask

    task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        push_ctrl(w, h, il);
        drive_ctrl(w, h, il);
    endtask

    task automatic send_pixel(input logic [W-1:0] d, input logic eov);
        bit ok;
        ok               = 0;
        din_valid        = 1'b1;
        din_data         = d;
        din_end_of_video = eov;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            if (acc_seen) begin
                ok = 1;
                break;
            end
        end
        din_valid        = 1'b0;
        din_end_of_video = 1'b0;
        if (!ok) chk("pixel_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_video(input int n, input bit gaps, input bit pattern);
        logic [W-1:0] px[$];
        logic [W-1:0] d;
        logic         lastb;
        for (int i = 0; i < n; i++) begin
            d = pattern ? {8'(3*i + 1), 8'(3*i + 2), 8'(3*i + 3)} : W'($urandom);
            px.push_back(d);
        end
        exp_q.push_back({24'h000000, 1'b1, 1'b0});
        for (int i = 0; i < n; i++) begin
            lastb = (i == n - 1);
            exp_q.push_back({px[i], 1'b0, lastb});
        end
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cyc();
            send_pixel(px[i], i == n - 1);
        end
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) cyc();
        if (exp_q.size() != 0) begin
            chk({nm, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        cyc();
        cyc();
        chk({nm, "_idle_valid"}, 64'(dout_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        int           got;

        tests = 0;
        errs  = 0;
        mode  = 0;
        mon_en = 0;
        acc_seen = 0;
        lat_pend = 0;
        hold_vld = 0;
        rst = 1'b1;
        din_valid = 1'b0;
        din_data = '0;
        din_end_of_video = 1'b0;
        ctrl_send = 1'b0;
        ctrl_width = '0;
        ctrl_height = '0;
        ctrl_interlaced = '0;
        dout_ready = 1'b0;

        tbl[0] = '{16'd1920,  16'd1080,  4'h0, 0, 24'h080700, 24'h040000, 24'h000803};
        tbl[1] = '{16'd640,   16'd480,   4'h3, 1, 24'h080200, 24'h010000, 24'h03000E};
        tbl[2] = '{16'hABCD,  16'h1234,  4'h5, 2, 24'h0C0B0A, 24'h02010D, 24'h050403};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_sop", 64'(dout_startofpacket), 64'd0);
        chk("rst_eop", 64'(dout_endofpacket), 64'd0);
        chk("rst_data", 64'(dout_data), 64'd0);
        chk("rst_ctrl_busy", 64'(ctrl_busy), 64'd0);
        chk("rst_din_ready", 64'(din_ready), 64'd0);
`ifdef VIP_ENC_LENGTH_CHECK_EN
        chk("rst_length_error", 64'(length_error), 64'd0);
        chk("rst_last_pkt_pixels", 64'(last_pkt_pixels), 64'd0);
`endif
        rst = 1'b0;
        mon_en = 1;
        cyc();

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            exp_q.push_back({24'h00000F, 1'b1, 1'b0});
            exp_q.push_back({tbl[i].b1, 1'b0, 1'b0});
            exp_q.push_back({tbl[i].b2, 1'b0, 1'b0});
            exp_q.push_back({tbl[i].b3, 1'b0, 1'b1});
            drive_ctrl(tbl[i].w, tbl[i].h, tbl[i].il);
            chk("tbl_busy_after_send", 64'(ctrl_busy), 64'd1);
            drain("tbl_ctrl");
            chk("tbl_busy_cleared", 64'(ctrl_busy), 64'd0);
        end

        mode = 0;
        send_video(4, 0, 1);
        drain("video_ready1");

        mode = 1;
        send_video(4, 0, 1);
        drain("video_toggle");

        mode = 0;
        send_video(1, 0, 0);
        drain("single_pixel");

        mode = 0;
        begin
            logic [W-1:0] px[6];
            exp_q.push_back({24'h000000, 1'b1, 1'b0});
            for (int i = 0; i < 6; i++) begin
                px[i] = W'($urandom);
                exp_q.push_back({px[i], 1'b0, i == 5});
            end
            send_pixel(px[0], 1'b0);
            send_pixel(px[1], 1'b0);
            send_ctrl(16'd100, 16'd50, 4'h2);
            chk("mid_video_busy", 64'(ctrl_busy), 64'd1);
            for (int i = 2; i < 6; i++) begin
                send_pixel(px[i], i == 5);
                chk("mid_video_busy_hold", 64'(ctrl_busy), 64'd1);
            end
            drain("ctrl_mid_video");
            chk("mid_video_busy_cleared", 64'(ctrl_busy), 64'd0);
        end

        mode = 0;
        d = W'($urandom);
        push_ctrl(16'd33, 16'd44, 4'h1);
        exp_q.push_back({24'h000000, 1'b1, 1'b0});
        exp_q.push_back({d, 1'b0, 1'b1});
        ctrl_send = 1'b1;
        ctrl_width = 16'd33;
        ctrl_height = 16'd44;
        ctrl_interlaced = 4'h1;
        din_valid = 1'b1;
        din_data = d;
        din_end_of_video = 1'b1;
        got = -1;
        for (int c = 0; c < 50; c++) begin
            cyc();
            ctrl_send = 1'b0;
            if (acc_seen) begin
                got = c;
                break;
            end
        end
        din_valid = 1'b0;
        din_end_of_video = 1'b0;
        chk("ctrl_priority_din_ready_wait", 64'(got), 64'd7);
        drain("ctrl_priority");

        mode = 2;
        for (int op = 0; op < 40; op++) begin
            if ($urandom_range(0, 9) < 3)
                send_ctrl(16'($urandom), 16'($urandom), 4'($urandom));
            else
                send_video($urandom_range(1, 8), 1, 0);
        end
        drain("random");
        chk("random_busy_cleared", 64'(ctrl_busy), 64'd0);

`ifdef VIP_ENC_LENGTH_CHECK_EN
        mode = 0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("len_rst_error", 64'(length_error), 64'd0);
        chk("len_rst_pixels", 64'(last_pkt_pixels), 64'd0);
        send_ctrl(16'd4, 16'd2, 4'h0);
        send_video(8, 0, 0);
        drain("len_ok");
        chk("len_ok_error", 64'(length_error), 64'd0);
        chk("len_ok_pixels", 64'(last_pkt_pixels), 64'd8);
        send_video(7, 0, 0);
        drain("len_short");
        chk("len_short_error", 64'(length_error), 64'd1);
        chk("len_short_pixels", 64'(last_pkt_pixels), 64'd7);
`endif

        mode = 0;
        mon_en = 0;
        exp_q.delete();
        send_ctrl(16'd8, 16'd8, 4'h0);
        exp_q.delete();
        din_valid = 1'b1;
        din_data = W'($urandom);
        din_end_of_video = 1'b0;
        repeat (9) cyc();
        rst = 1'b1;
        #1;
        chk("midrst_dout_valid", 64'(dout_valid), 64'd0);
        chk("midrst_sop", 64'(dout_startofpacket), 64'd0);
        chk("midrst_eop", 64'(dout_endofpacket), 64'd0);
        chk("midrst_data", 64'(dout_data), 64'd0);
        chk("midrst_busy", 64'(ctrl_busy), 64'd0);
        chk("midrst_din_ready", 64'(din_ready), 64'd0);
`ifdef VIP_ENC_LENGTH_CHECK_EN
        chk("midrst_length_error", 64'(length_error), 64'd0);
        chk("midrst_last_pkt_pixels", 64'(last_pkt_pixels), 64'd0);
`endif
        din_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        mon_en = 1;
        send_video(3, 0, 0);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
